// File: rtl/fib_stack.sv
// fib_stack -- LIFO operand stack for the Fibonacci controller.
//
// Holds pending n operands and partial sums. The top of stack is held in a
// dedicated register so dout never reads the array combinationally.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   push   in   push din this cycle
//   pop    in   discard top entry this cycle (push+pop = replace top)
//   din    in   [WIDTH-1:0] data to push
//   dout   out  [WIDTH-1:0] registered top of stack, 0 when empty
//   empty  out  no entries held
//   full   out  DEPTH entries held
//   count  out  [AW:0] number of valid entries
//   err    out  sticky overflow/underflow flag
//
// Optional feature macro: FIB_STACK_ERR_EN
//   defined     -> err is set on overflow/underflow and held until reset
//   not defined -> err tied to 0, illegal operations silently ignored
module fib_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             err
);

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_TWO  = (AW+1)'(2);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp;
  logic [AW:0]      sp_next;
  logic [WIDTH-1:0] top_q;
  logic             empty_q;
  logic             full_q;

  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // push+pop on an empty stack degenerates to a plain push
  assign do_push = push && ((!pop && !full_q) || (pop && empty_q));
  assign do_pop  = pop && !push && !empty_q;
  assign do_repl = push && pop && !empty_q;

  // Low AW bits of sp index modulo DEPTH, so sp==DEPTH still yields the
  // right slot for replace (sp-1) and pop (sp-2).
  assign wr_idx = do_push ? sp[AW-1:0] : (sp[AW-1:0] - AW'(1));
  assign rd_idx = sp[AW-1:0] - AW'(2);

  always_comb begin
    sp_next = sp;
    if (do_push)
      sp_next = sp + SP_ONE;
    else if (do_pop)
      sp_next = sp - SP_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= '0;
      top_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp      <= sp_next;
      empty_q <= (sp_next == '0);
      full_q  <= (sp_next == SP_FULL);
      if (do_push || do_repl)
        top_q <= din;
      else if (do_pop)
        top_q <= (sp >= SP_TWO) ? mem[rd_idx] : '0;
    end
  end

  // storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push || do_repl)
      mem[wr_idx] <= din;
  end

  assign dout  = top_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = sp;

`ifdef FIB_STACK_ERR_EN
  logic ovf;
  logic unf;
  logic err_q;

  assign ovf = push && !pop && full_q;
  assign unf = pop && empty_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_q <= 1'b0;
    else if (ovf || unf)
      err_q <= 1'b1;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && ovf)
      $display("fib_stack: overflow at %0t", $time);
    if (rst && unf)
      $display("fib_stack: underflow at %0t", $time);
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stack.sv
module tb_fib_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             err;

  int checks;
  int errors;
  logic err_on_fault;

  fib_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp_dout, input int exp_count);
    check({tag, ".dout"},  32'(dout),  32'(exp_dout));
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".empty"}, 32'(empty), (exp_count == 0) ? 32'd1 : 32'd0);
    check({tag, ".full"},  32'(full),  (exp_count == DEPTH) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef FIB_STACK_ERR_EN
    err_on_fault = 1'b1;
`else
    err_on_fault = 1'b0;
`endif
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_state("rst_held", 0, 0);
    check("rst_held.err", 32'(err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0);
      check_state("idle", 0, 0);
    end

    // push 5, 8, 13 then pop three times
    step(1'b1, 1'b0, 16'd5);  check_state("push5", 5, 1);
    step(1'b1, 1'b0, 16'd8);  check_state("push8", 8, 2);
    step(1'b1, 1'b0, 16'd13); check_state("push13", 13, 3);
    step(1'b0, 1'b1, '0);     check_state("pop_a", 8, 2);
    step(1'b0, 1'b1, '0);     check_state("pop_b", 5, 1);
    step(1'b0, 1'b1, '0);     check_state("pop_c", 0, 0);
    check("no_err_yet", 32'(err), 32'd0);

    // fill to DEPTH
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, WIDTH'(i));
      check_state("fill", i, i);
    end
    step(1'b1, 1'b0, 16'd99);
    check_state("overflow", 16, 16);
    check("overflow.err", 32'(err), 32'(err_on_fault));

    // replace at full, then drain
    step(1'b1, 1'b1, 16'd77);
    check_state("repl_full", 77, 16);
    step(1'b0, 1'b1, '0);
    check_state("pop_after_repl", 15, 15);
    for (int i = 15; i >= 1; i--) begin
      step(1'b0, 1'b1, '0);
      check_state("drain", i - 1, i - 1);
    end

    // simultaneous push/pop on [3, 7]
    step(1'b1, 1'b0, 16'd3);
    step(1'b1, 1'b0, 16'd7);
    check_state("stack37", 7, 2);
    step(1'b1, 1'b1, 16'd21);
    check_state("replace21", 21, 2);
    step(1'b0, 1'b1, '0);
    check_state("pop_to3", 3, 1);
    step(1'b0, 1'b1, '0);
    check_state("pop_to_empty", 0, 0);

    // underflow, then push+pop on empty
    step(1'b0, 1'b1, '0);
    check_state("underflow", 0, 0);
    check("underflow.err", 32'(err), 32'(err_on_fault));
    step(1'b1, 1'b1, 16'd4);
    check_state("pushpop_empty", 4, 1);

    // push then immediate pop restores prior top
    step(1'b1, 1'b0, 16'd9);
    check_state("push9", 9, 2);
    step(1'b0, 1'b1, '0);
    check_state("restore4", 4, 1);

    // async reset between edges with three entries
    step(1'b1, 1'b0, 16'd11);
    step(1'b1, 1'b0, 16'd12);
    check_state("three", 12, 3);
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 0, 0);
    check("async_rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    check_state("post_rst", 0, 0);
    step(1'b1, 1'b0, 16'd42);
    check_state("post_rst_push", 42, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
